// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;
  typedef enum logic {OWN_I, OWN_D} arb_owner_t;

  localparam int CNT_WIDTH = 4;

endpackage

// File: rtl/mem_arb_if.sv
// Fetch port, data port and memory bus of the arbiter, bundled as one interface.
interface mem_arb_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  i_req;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic                  i_gnt;
    logic                  i_rvalid;
    logic [DATA_WIDTH-1:0] i_rdata;

    logic                  d_req;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [DATA_WIDTH-1:0] d_rdata;

    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter_busy_ctr.sv
// Loadable down-counter timing the memory latency slot; zero_o marks the final cycle.
module arb_busy_ctr
    import mem_arb_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic [CNT_WIDTH-1:0] load_val_i,
    output logic                 zero_o
);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (cnt_q != '0)
            cnt_d = cnt_q - CNT_ONE;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data requesters onto one single-port memory with a fixed read latency.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_LATENCY  = 2,
    parameter int MAX_D_STREAK = 4
) (
    input  logic      clk,
    input  logic      rst,
    mem_arb_if.slave  bus
);
    localparam logic [CNT_WIDTH-1:0] LAT_LOAD   = CNT_WIDTH'(MEM_LATENCY - 1);
    localparam logic [CNT_WIDTH-1:0] STREAK_MAX = CNT_WIDTH'(MAX_D_STREAK);
    localparam logic [CNT_WIDTH-1:0] STREAK_ONE = 1;

    arb_state_t           state_q, state_d;
    arb_owner_t           owner_q, owner_d;
    logic                 rd_q, rd_d;
    logic [CNT_WIDTH-1:0] streak_q, streak_d;

    logic ctr_zero, issue_ok, final_cyc, d_win, i_win, rvalid_any;

    arb_busy_ctr u_busy_ctr (
        .clk        (clk),
        .rst        (rst),
        .load_i     (d_win | i_win),
        .load_val_i (LAT_LOAD),
        .zero_o     (ctr_zero)
    );

    always_comb begin
        issue_ok  = (state_q == ARB_IDLE) || ctr_zero;
        final_cyc = (state_q == ARB_BUSY) && ctr_zero;
        // A full streak yields exactly one slot to a waiting fetch.
        d_win = !rst && issue_ok && bus.d_req && !(bus.i_req && (streak_q == STREAK_MAX));
        i_win = !rst && issue_ok && !d_win && bus.i_req;

        bus.d_gnt     = d_win;
        bus.i_gnt     = i_win;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (d_win) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = bus.d_we;
            bus.mem_addr  = bus.d_addr;
            bus.mem_wdata = bus.d_wdata;
        end else if (i_win) begin
            bus.mem_en    = 1'b1;
            bus.mem_addr  = bus.i_addr;
            bus.mem_wdata = bus.d_wdata;
        end

        rvalid_any   = !rst && final_cyc && rd_q;
        bus.i_rvalid = rvalid_any && (owner_q == OWN_I);
        bus.d_rvalid = rvalid_any && (owner_q == OWN_D);
        bus.i_rdata  = bus.i_rvalid ? bus.mem_rdata : '0;
        bus.d_rdata  = bus.d_rvalid ? bus.mem_rdata : '0;

        state_d = state_q;
        owner_d = owner_q;
        rd_d    = rd_q;
        if (d_win || i_win) begin
            state_d = ARB_BUSY;
            owner_d = d_win ? OWN_D : OWN_I;
            rd_d    = d_win ? !bus.d_we : 1'b1;
        end else if (final_cyc) begin
            state_d = ARB_IDLE;
        end

        streak_d = streak_q;
        if (!bus.i_req || i_win)
            streak_d = '0;
        else if (d_win && (streak_q != STREAK_MAX))
            streak_d = streak_q + STREAK_ONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            owner_q  <= OWN_D;
            rd_q     <= 1'b0;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rd_q     <= rd_d;
            streak_q <= streak_d;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Cycle-scripted directed bench for mem_arbiter (latency 2 main instance, latency 1 store instance).
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct packed {
        logic          rst;
        logic          i_req;
        logic [AW-1:0] i_addr;
        logic          d_req;
        logic          d_we;
        logic [AW-1:0] d_addr;
        logic [DW-1:0] d_wdata;
    } in_t;

    typedef struct packed {
        logic          i_gnt;
        logic          d_gnt;
        logic          mem_en;
        logic          mem_we;
        logic [AW-1:0] mem_addr;
        logic [DW-1:0] mem_wdata;
        logic          i_rvalid;
        logic [DW-1:0] i_rdata;
        logic          d_rvalid;
        logic [DW-1:0] d_rdata;
    } out_t;

    typedef struct {
        in_t  in;
        out_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    mem_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus  ();
    mem_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(2), .MAX_D_STREAK(4))
        dut (.clk(clk), .rst(rst), .bus(bus));
    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(1), .MAX_D_STREAK(4))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));

    function automatic logic [DW-1:0] mdl(input logic [AW-1:0] a);
        return (a == 32'h10) ? 32'hDEAD_BEEF : (a ^ 32'hA5A5_0000);
    endfunction

    // Memory model: data for the address presented in cycle T appears during T+2.
    logic [DW-1:0] snap = '0, s1 = '0, s2 = '0;
    always @(negedge clk) snap <= mdl(bus.mem_addr);
    always @(posedge clk) begin
        s1 <= snap;
        s2 <= s1;
    end
    assign bus.mem_rdata  = s2;
    assign bus1.mem_rdata = '0;

    function automatic in_t mk_in(input logic r, input logic ir, input logic [AW-1:0] ia,
                                  input logic dr, input logic dwe, input logic [AW-1:0] da,
                                  input logic [DW-1:0] dwd);
        in_t v;
        v.rst = r; v.i_req = ir; v.i_addr = ia;
        v.d_req = dr; v.d_we = dwe; v.d_addr = da; v.d_wdata = dwd;
        return v;
    endfunction

    function automatic out_t mk_out(input logic ig, input logic dg, input logic en, input logic we,
                                    input logic [AW-1:0] ma, input logic [DW-1:0] mw,
                                    input logic iv, input logic [DW-1:0] ird,
                                    input logic dv, input logic [DW-1:0] drd);
        out_t o;
        o.i_gnt = ig; o.d_gnt = dg; o.mem_en = en; o.mem_we = we;
        o.mem_addr = ma; o.mem_wdata = mw;
        o.i_rvalid = iv; o.i_rdata = ird; o.d_rvalid = dv; o.d_rdata = drd;
        return o;
    endfunction

    function automatic out_t o_idle();
        return mk_out(0, 0, 0, 0, '0, '0, 0, '0, 0, '0);
    endfunction

    function automatic in_t in_idle();
        return mk_in(0, 0, '0, 0, 0, '0, '0);
    endfunction

    function automatic out_t sample();
        return mk_out(bus.i_gnt, bus.d_gnt, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata,
                      bus.i_rvalid, bus.i_rdata, bus.d_rvalid, bus.d_rdata);
    endfunction

    task automatic add(input in_t i, input out_t o);
        vec_t v;
        v.in  = i;
        v.exp = o;
        vq.push_back(v);
    endtask

    task automatic drive(input in_t v);
        rst         = v.rst;
        bus.i_req   = v.i_req;
        bus.i_addr  = v.i_addr;
        bus.d_req   = v.d_req;
        bus.d_we    = v.d_we;
        bus.d_addr  = v.d_addr;
        bus.d_wdata = v.d_wdata;
    endtask

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus1.i_req = 1'b0; bus1.i_addr = '0; bus1.d_req = 1'b0;
        bus1.d_we = 1'b0; bus1.d_addr = '0; bus1.d_wdata = '0;

        // Reset with requests pending, then fetch read.
        add(mk_in(1, 1, 'h10, 1, 0, 'h80, 0), o_idle());
        add(mk_in(1, 0, 0, 0, 0, 0, 0),       o_idle());
        add(mk_in(0, 1, 'h10, 0, 0, 0, 0),    mk_out(1, 0, 1, 0, 'h10, 0, 0, 0, 0, 0));
        add(in_idle(),                        o_idle());
        add(in_idle(),                        mk_out(0, 0, 0, 0, 0, 0, 1, mdl('h10), 0, 0));
        add(in_idle(),                        o_idle());
        // Tie: data first, fetch granted alongside data rvalid.
        add(mk_in(0, 1, 'h20, 1, 0, 'h80, 0), mk_out(0, 1, 1, 0, 'h80, 0, 0, 0, 0, 0));
        add(mk_in(0, 1, 'h20, 0, 0, 0, 0),    o_idle());
        add(mk_in(0, 1, 'h20, 0, 0, 0, 0),    mk_out(1, 0, 1, 0, 'h20, 0, 0, 0, 1, mdl('h80)));
        add(in_idle(),                        o_idle());
        add(in_idle(),                        mk_out(0, 0, 0, 0, 0, 0, 1, mdl('h20), 0, 0));
        // Stores: one-cycle write strobe, no rvalid, next grant two cycles later.
        add(mk_in(0, 0, 0, 1, 1, 'h40, 'h1234), mk_out(0, 1, 1, 1, 'h40, 'h1234, 0, 0, 0, 0));
        add(mk_in(0, 0, 0, 1, 1, 'h44, 'h5678), o_idle());
        add(mk_in(0, 0, 0, 1, 1, 'h44, 'h5678), mk_out(0, 1, 1, 1, 'h44, 'h5678, 0, 0, 0, 0));
        add(in_idle(),                        o_idle());
        add(in_idle(),                        o_idle());
        // Reset mid-read discards the read; regrant right after reset.
        add(mk_in(0, 1, 'h30, 0, 0, 0, 0),    mk_out(1, 0, 1, 0, 'h30, 0, 0, 0, 0, 0));
        add(mk_in(1, 1, 'h30, 0, 0, 0, 0),    o_idle());
        add(mk_in(0, 1, 'h30, 0, 0, 0, 0),    mk_out(1, 0, 1, 0, 'h30, 0, 0, 0, 0, 0));
        add(in_idle(),                        o_idle());
        add(in_idle(),                        mk_out(0, 0, 0, 0, 0, 0, 1, mdl('h30), 0, 0));
        // Withdrawn data request while busy.
        add(mk_in(0, 1, 'h50, 0, 0, 0, 0),    mk_out(1, 0, 1, 0, 'h50, 0, 0, 0, 0, 0));
        add(mk_in(0, 0, 0, 1, 0, 'h60, 0),    o_idle());
        add(in_idle(),                        mk_out(0, 0, 0, 0, 0, 0, 1, mdl('h50), 0, 0));
        add(in_idle(),                        o_idle());

        foreach (vq[k]) begin
            drive(vq[k].in);
            @(negedge clk);
            check($sformatf("vec%0d", k), 256'(sample()), 256'(vq[k].exp));
            next_cycle();
        end

        // Starvation: both held; grants D,D,D,D,I,D on even cycles, none on odd.
        drive(mk_in(0, 1, 'h70, 1, 0, 'h90, 0));
        for (int j = 0; j < 12; j++) begin
            logic [1:0] exp_g;
            exp_g = (j % 2 == 1) ? 2'b00 : ((j == 8) ? 2'b10 : 2'b01);
            @(negedge clk);
            check($sformatf("streak%0d {i_gnt,d_gnt}", j), 256'({bus.i_gnt, bus.d_gnt}), 256'(exp_g));
            next_cycle();
        end
        drive(in_idle());
        repeat (3) next_cycle();

        // Latency 1: back-to-back stores granted every cycle.
        for (int k = 0; k < 4; k++) begin
            logic [AW-1:0] a;
            logic [DW-1:0] w;
            a = AW'(32'h100 + 4 * k);
            w = DW'(k + 1);
            bus1.d_req = 1'b1; bus1.d_we = 1'b1; bus1.d_addr = a; bus1.d_wdata = w;
            @(negedge clk);
            check($sformatf("lat1_store%0d", k),
                  256'({bus1.d_gnt, bus1.mem_en, bus1.mem_we, bus1.mem_addr, bus1.mem_wdata, bus1.d_rvalid}),
                  256'({1'b1, 1'b1, 1'b1, a, w, 1'b0}));
            next_cycle();
        end
        bus1.d_req = 1'b0; bus1.d_we = 1'b0;
        @(negedge clk);
        check("lat1_after {d_gnt,mem_en,d_rvalid}", 256'({bus1.d_gnt, bus1.mem_en, bus1.d_rvalid}), 256'(3'b000));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
